// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler feeding a UART transmitter: one byte FIFO per
// requester, round-robin arbitration, and an FSM that follows each frame to completion.
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Req0_DV,
  input  logic [7:0] i_Req0_Byte,
  output logic       o_Req0_Ready,
  input  logic       i_Req1_DV,
  input  logic [7:0] i_Req1_Byte,
  output logic       o_Req1_Ready,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Grant,
  output logic       o_Busy,
  output logic       o_Drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACTIVE,
    S_WAIT_DONE,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_mem [2][FIFO_DEPTH];
  logic [AW-1:0] r_wr  [2];
  logic [AW-1:0] r_rd  [2];
  logic [CW-1:0] r_cnt [2];
  logic          r_tx_dv;
  logic [7:0]    r_tx_byte;
  logic          r_grant;
  logic          r_drop;

  logic [1:0]    w_dv;
  logic [1:0]    w_ready;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_not_empty;
  logic [7:0]    w_byte [2];
  logic          w_sel;

  assign w_dv           = {i_Req1_DV, i_Req0_DV};
  assign w_byte[0]      = i_Req0_Byte;
  assign w_byte[1]      = i_Req1_Byte;
  // Ready comes from the registered count, so a pop in the same cycle never opens a slot.
  assign w_ready[0]     = (r_cnt[0] < FULL_COUNT);
  assign w_ready[1]     = (r_cnt[1] < FULL_COUNT);
  assign w_not_empty[0] = (r_cnt[0] != '0);
  assign w_not_empty[1] = (r_cnt[1] != '0);
  assign w_push         = w_dv & w_ready;

  // NOTE: FIFO storage has no reset; the pointers and counts alone decide what is valid.
  always_ff @(posedge i_Clock) begin
    for (int k = 0; k < 2; k++) begin
      if (w_push[k]) r_mem[k][r_wr[k]] <= w_byte[k];
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int k = 0; k < 2; k++) begin
        r_wr[k]  <= '0;
        r_rd[k]  <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_push[k]) r_wr[k] <= r_wr[k] + AW'(1);
        if (w_pop[k])  r_rd[k] <= r_rd[k] + AW'(1);
        r_cnt[k] <= r_cnt[k] + CW'(w_push[k]) - CW'(w_pop[k]);
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    w_next = r_state;
    w_pop  = '0;
    w_sel  = r_grant;
    case (r_state)
      S_SYNC: begin
        if (!i_Tx_Active && !i_Tx_Done) w_next = S_IDLE;
      end
      S_IDLE: begin
        // On a tie the requester that did not own the last frame wins.
        if (&w_not_empty) w_sel = ~r_grant;
        else              w_sel = w_not_empty[1];
        if (|w_not_empty) begin
          w_pop[w_sel] = 1'b1;
          w_next       = S_LAUNCH;
        end
      end
      S_LAUNCH:      w_next = S_WAIT_ACTIVE;
      S_WAIT_ACTIVE: if (i_Tx_Active) w_next = S_WAIT_DONE;
      S_WAIT_DONE:   if (i_Tx_Done)   w_next = S_DRAIN;
      // Done may be held for several cycles; wait it out so one frame is never counted twice.
      S_DRAIN:       if (!i_Tx_Done)  w_next = S_IDLE;
      default:       w_next = S_SYNC;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state   <= S_SYNC;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= '0;
      r_grant   <= 1'b1;
      r_drop    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx_dv <= (w_next == S_LAUNCH);
      r_drop  <= |(w_dv & ~w_ready);
      if (|w_pop) begin
        r_tx_byte <= r_mem[w_sel][r_rd[w_sel]];
        r_grant   <= w_sel;
      end
    end
  end

  assign o_Req0_Ready = w_ready[0];
  assign o_Req1_Ready = w_ready[1];
  assign o_Tx_DV      = r_tx_dv;
  assign o_Tx_Byte    = r_tx_byte;
  assign o_Grant      = r_grant;
  assign o_Busy       = (r_state != S_IDLE);
  assign o_Drop       = r_drop;

endmodule
